// File: rtl/shift_register_8b_piso_tx_pkg.sv
// Shared types and constants for the PISO serializer.
// Holds the FSM state encoding and the default frame width.
package shift_register_8b_piso_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_register_8b_piso_tx_if.sv
// Parallel-in handshake plus serial-out bundle of the PISO serializer.
// The master offers words and drives the bit-rate enable; the slave is the serializer.
interface shift_register_8b_piso_tx_if
  import shift_register_8b_piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             shift_en;
  logic             s_out;
  logic             s_valid;
  logic             frame_done;

  modport master (
    output din, din_valid, shift_en,
    input  din_ready, s_out, s_valid, frame_done
  );

  modport slave (
    input  din, din_valid, shift_en,
    output din_ready, s_out, s_valid, frame_done
  );

endinterface

// File: rtl/shift_register_8b_piso_tx_piso_bit_counter.sv
// Bit position counter for one frame: clears on command, saturates at the last bit.
// tc flags the final bit position (WIDTH-1).
module piso_bit_counter
  import shift_register_8b_piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_register_8b_piso_tx.sv
// Parallel-in serial-out transmitter: captures a word on handshake and shifts it out
// one bit per enabled cycle, reloading in the last-bit cycle for gapless frames.
module shift_register_8b_piso_tx
  import shift_register_8b_piso_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  shift_register_8b_piso_tx_if.slave bus
);

  localparam int OUT_BIT = MSB_FIRST ? WIDTH - 1 : 0;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted;

  logic in_shift;
  logic advance;
  logic last_bit;
  logic frame_done;
  logic din_ready;
  logic transfer;

  assign in_shift   = (state_q == ST_SHIFT);
  assign advance    = in_shift & bus.shift_en;
  // Reset wins over an in-flight frame, so the final-bit strobe is suppressed too.
  assign frame_done = advance & last_bit & ~reset;
  assign din_ready  = ~in_shift | frame_done;
  assign transfer   = bus.din_valid & din_ready;

  assign bus.din_ready  = din_ready;
  assign bus.frame_done = frame_done;
  assign bus.s_valid    = in_shift;
  assign bus.s_out      = in_shift & shreg_q[OUT_BIT];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shreg_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shreg_q[gi+1];
        end
      end
    end
  endgenerate

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (transfer | frame_done),
    .enable (advance),
    .tc     (last_bit)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (transfer) begin
      state_d = ST_SHIFT;
      shreg_d = bus.din;
    end else begin
      if (advance) begin
        shreg_d = shifted;
      end
      if (frame_done) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_shift_register_8b_piso_tx.sv
// Bench for the PISO transmitter: MSB-first and LSB-first instances share stimulus and
// are compared each cycle against a queue-of-pending-bits reference model.
module tb_shift_register_8b_piso_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shift_register_8b_piso_tx_if #(.WIDTH(W)) bus_m ();
  shift_register_8b_piso_tx_if #(.WIDTH(W)) bus_l ();

  shift_register_8b_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  shift_register_8b_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  int checks = 0;
  int errors = 0;

  bit         q_m[$];
  bit         q_l[$];
  logic [W-1:0] words_m[$];
  logic [W-1:0] words_l[$];
  logic [W-1:0] sipo_m;
  logic [W-1:0] sipo_l;
  logic [W-1:0] a5_bits;
  int           a5_n;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic [W-1:0] d, input logic v, input logic se, input logic rs);
    bit   ev, eo_m, eo_l, ed, er, xfer;
    logic ob_m, ob_l;
    @(negedge clk);
    bus_m.din = d;  bus_m.din_valid = v;  bus_m.shift_en = se;
    bus_l.din = d;  bus_l.din_valid = v;  bus_l.shift_en = se;
    reset = rs;
    #1;
    ev   = (q_m.size() != 0);
    eo_m = ev ? q_m[0] : 1'b0;
    eo_l = ev ? q_l[0] : 1'b0;
    ed   = (q_m.size() == 1) && se && !rs;
    er   = !ev || ed;
    xfer = v && er && !rs;
    ob_m = bus_m.s_out;
    ob_l = bus_l.s_out;
    chk("m_s_valid",    bus_m.s_valid,    ev);
    chk("m_s_out",      ob_m,             eo_m);
    chk("m_frame_done", bus_m.frame_done, ed);
    chk("m_din_ready",  bus_m.din_ready,  er);
    chk("l_s_valid",    bus_l.s_valid,    ev);
    chk("l_s_out",      ob_l,             eo_l);
    chk("l_frame_done", bus_l.frame_done, ed);
    chk("l_din_ready",  bus_l.din_ready,  er);
    @(posedge clk);
    if (rs) begin
      q_m.delete(); q_l.delete(); words_m.delete(); words_l.delete();
    end else begin
      if (se && ev) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
        sipo_m = {sipo_m[W-2:0], ob_m};
        sipo_l = {ob_l, sipo_l[W-1:1]};
        if (a5_n < W) begin
          a5_bits = {a5_bits[W-2:0], ob_m};
          a5_n++;
        end
        if (q_m.size() == 0) begin
          chk_word("m_sipo_word", sipo_m, words_m.pop_front());
          chk_word("l_sipo_word", sipo_l, words_l.pop_front());
        end
      end
      if (xfer) begin
        for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
        for (int i = 0; i < W; i++) q_l.push_back(d[i]);
        words_m.push_back(d);
        words_l.push_back(d);
        $display("xfer t=%0t din=%h", $time, d);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * W && q_m.size() != 0; i++) step('0, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", q_m.size() == 0, 1'b1);
  endtask

  initial begin
    bus_m.din = '0; bus_m.din_valid = 1'b0; bus_m.shift_en = 1'b0;
    bus_l.din = '0; bus_l.din_valid = 1'b0; bus_l.shift_en = 1'b0;
    sipo_m = '0; sipo_l = '0; a5_bits = '0; a5_n = W;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, then idle
    step('0, 1'b0, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1, 1'b0);

    // Single 0xA5 frame; capture the MSB-first bit stream explicitly
    a5_n = 0;
    step(8'hA5, 1'b1, 1'b1, 1'b0);
    drain();
    chk_word("a5_stream", a5_bits, 8'hA5);
    step('0, 1'b0, 1'b1, 1'b0);

    // Back-to-back 0xFF then 0x00; junk din while not ready must be ignored
    step(8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (W - 1) step(W'($urandom), 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    repeat (W - 1) step(W'($urandom), 1'b1, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);

    // 0xC3 with a three-cycle stall after the second bit
    step(8'hC3, 1'b1, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(W'($urandom), 1'b1, 1'b0, 1'b0);
    drain();

    // Reset mid-frame abandons 0x5A; then 0x81 must serialize cleanly
    step(8'h5A, 1'b1, 1'b1, 1'b0);
    repeat (4) step('0, 1'b0, 1'b1, 1'b0);
    step(8'h77, 1'b1, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1, 1'b0);
    step(8'h81, 1'b1, 1'b1, 1'b0);
    drain();

    // 0x01 exercises LSB-first ordering and word reconstruction
    step(8'h01, 1'b1, 1'b1, 1'b0);
    drain();

    // Randomized traffic with stalls and occasional resets
    for (int n = 0; n < 400; n++) begin
      step(W'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
           ($urandom_range(49) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_8b_piso_tx.md
SHIFT_REGISTER_8B_PISO_TX -- requirements
Module: shift_register_8b_piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, frame length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 din_valid  input  1  din holds a word offered for transfer.
REQ-008 din_ready  output  1  block can accept a word this cycle.
REQ-009 shift_en  input  1  bit-rate enable; 0 stalls shifting.
REQ-010 s_out  output  1  serial data; drives a downstream SIPO s_in.
REQ-011 s_valid  output  1  s_out carries a frame bit this cycle.
REQ-012 frame_done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-013 Transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; din captured into an internal WIDTH-bit shift register.
REQ-014 FSM states SHALL be IDLE and SHIFT only.
REQ-015 IDLE: din_ready=1, s_valid=0, s_out=0; transfer -> SHIFT with bit counter=0.
REQ-016 SHIFT: s_valid=1; s_out SHALL be register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
REQ-017 First bit SHALL appear on s_out the cycle after the transfer edge (latency 1).
REQ-018 In SHIFT with shift_en=1, each edge SHALL advance register by one bit toward the output end and increment counter; vacated bit filled with 0.
REQ-019 In SHIFT with shift_en=0, register, counter, s_out and s_valid SHALL hold; frame_done SHALL be 0.
REQ-020 frame_done SHALL be 1 exactly while counter=WIDTH-1 and shift_en=1, in SHIFT.
REQ-021 din_ready SHALL be 1 in IDLE and in the frame_done cycle; 0 otherwise.
REQ-022 Transfer in the frame_done cycle SHALL reload the register, clear counter, stay in SHIFT: gapless back-to-back frames.
REQ-023 frame_done cycle without transfer -> IDLE.
REQ-024 din_valid while din_ready=0 SHALL be ignored; din not sampled.
REQ-025 Counter width SHALL be clog2(WIDTH); no wrap beyond WIDTH-1.
REQ-026 All outputs SHALL be registered or decoded only from registered state; no combinational path din/din_valid -> s_out.

Reset
REQ-027 reset=1 on an edge SHALL force IDLE, counter=0, register=0, s_out=0, s_valid=0, frame_done=0; din_ready=1 the following cycle.
REQ-028 reset SHALL take priority over transfer and shift_en; a frame in progress is abandoned, no frame_done emitted.
REQ-029 Output values before the first reset edge are unspecified.

Structure
REQ-030 Shared package SHALL hold the state typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-031 Bit counter SHALL be a separate sub-module piso_bit_counter (clear, enable, terminal-count output); FSM and shift register stay in the top module.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, shift_en=1, din=8'hA5 one transfer -> s_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, s_valid=1 throughout, frame_done on 8th bit only, then IDLE.
REQ-033 din=8'hFF then 8'h00 held valid -> 16 contiguous s_valid cycles: eight 1s then eight 0s; din_ready high only in the two frame_done cycles.
REQ-034 din=8'hC3, shift_en low 3 cycles after 2nd bit -> s_out holds 1 for 3 cycles, then sequence resumes; total 11 s_valid cycles, one frame_done.
REQ-035 reset asserted after 4th bit of 8'h5A -> next cycle s_valid=0, s_out=0, din_ready=1; no frame_done; subsequent 8'h81 serializes correctly.
REQ-036 MSB_FIRST=0, din=8'h01 -> s_out 1,0,0,0,0,0,0,0; feeding a SIPO with outputs captured after frame_done reconstructs the word.
